// File: rtl/weight_buffer_pingpong.sv
// weight_buffer_pingpong: two-bank SIZExSIZE weight tile store feeding the
// systolic array preload path; one bank fills while the other streams.
// Ports:
//   clk, rst (async, active-low)
//   wr_valid/wr_ready/wr_addr/wr_data/wr_last : loader write channel
//   preload_req/preload_reuse/preload_busy    : tile stream request
//   weight_out/weight_out_valid/weight_out_last : one column per cycle
//   bank_full                                  : per-bank FULL flags
module weight_buffer_pingpong #(
   parameter int SIZE         = 8,
   parameter int WEIGHT_WIDTH = 5,
   parameter int ADDR_WIDTH   = $clog2(SIZE*SIZE),
   parameter int CNT_WIDTH    = $clog2(SIZE)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [WEIGHT_WIDTH-1:0]      wr_data,
   input  logic                         wr_last,
   input  logic                         preload_req,
   input  logic                         preload_reuse,
   output logic                         preload_busy,
   output logic [SIZE*WEIGHT_WIDTH-1:0] weight_out,
   output logic                         weight_out_valid,
   output logic                         weight_out_last,
   output logic [1:0]                   bank_full
);

   localparam int DEPTH = SIZE*SIZE;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } bank_st_t;

   bank_st_t st_q [2];
   bank_st_t st_d [2];

   logic wb_q, wb_d;
   logic rb_q, rb_d;
   logic pend_q, pend_d;
   logic reuse_q, reuse_d;
   logic vld_q, vld_d;
   logic last_q, last_d;
   logic [CNT_WIDTH-1:0] col_q, col_d;
   logic [CNT_WIDTH-1:0] rd_col;
   logic [SIZE*WEIGHT_WIDTH-1:0] out_q, out_d;
   logic [SIZE*WEIGHT_WIDTH-1:0] col_data;

   logic [WEIGHT_WIDTH-1:0] mem [2][DEPTH];

   logic wr_fire;
   logic commit;
   logic req_ok;
   logic rb_full;
   logic bypass;

   assign wr_ready     = (st_q[wb_q] == EMPTY);
   assign wr_fire      = wr_valid && wr_ready;
   assign commit       = wr_fire && wr_last;
   assign preload_busy = pend_q || vld_q;
   assign req_ok       = preload_req && !preload_busy;

   // A tile committing into the read bank this edge may start at once.
   assign rb_full = (st_q[rb_q] == FULL) || (commit && (wb_q == rb_q));
   assign bypass  = wr_fire && (wb_q == rb_q);

   // col_q holds the next column to issue while streaming.
   assign rd_col = vld_q ? col_q : '0;

   for (genvar r = 0; r < SIZE; r++) begin : g_lane
      logic [ADDR_WIDTH-1:0] ra;
      assign ra = ADDR_WIDTH'(r*SIZE) + ADDR_WIDTH'(rd_col);
      // Forward the write landing on the same edge as the start.
      assign col_data[r*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
         (bypass && (wr_addr == ra)) ? wr_data : mem[rb_q][ra];
   end

   // A reused bank reports full even while it streams.
   for (genvar b = 0; b < 2; b++) begin : g_full
      assign bank_full[b] = (st_q[b] == FULL) ||
                            ((st_q[b] == DRAIN) && reuse_q);
   end

   assign weight_out       = out_q;
   assign weight_out_valid = vld_q;
   assign weight_out_last  = last_q;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wb_q][wr_addr] <= wr_data;
      end
   end

   always_comb begin
      st_d[0] = st_q[0];
      st_d[1] = st_q[1];
      wb_d    = wb_q;
      rb_d    = rb_q;
      pend_d  = pend_q;
      reuse_d = reuse_q;
      col_d   = col_q;
      out_d   = out_q;
      vld_d   = 1'b0;
      last_d  = 1'b0;

      if (commit) begin
         st_d[wb_q] = FULL;
         wb_d       = ~wb_q;
      end

      if (vld_q) begin
         if (last_q) begin
            st_d[rb_q] = reuse_q ? FULL : EMPTY;
            rb_d       = reuse_q ? rb_q : ~rb_q;
         end else begin
            out_d  = col_data;
            vld_d  = 1'b1;
            last_d = (col_q == CNT_WIDTH'(SIZE-1));
            col_d  = col_q + 1'b1;
         end
      end else if (pend_q || req_ok) begin
         reuse_d = pend_q ? reuse_q : preload_reuse;
         if (rb_full) begin
            st_d[rb_q] = DRAIN;
            out_d      = col_data;
            vld_d      = 1'b1;
            last_d     = (SIZE == 1);
            col_d      = CNT_WIDTH'(1);
            pend_d     = 1'b0;
         end else begin
            pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q[0] <= EMPTY;
         st_q[1] <= EMPTY;
         wb_q    <= 1'b0;
         rb_q    <= 1'b0;
         pend_q  <= 1'b0;
         reuse_q <= 1'b0;
         col_q   <= '0;
         out_q   <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         st_q[0] <= st_d[0];
         st_q[1] <= st_d[1];
         wb_q    <= wb_d;
         rb_q    <= rb_d;
         pend_q  <= pend_d;
         reuse_q <= reuse_d;
         col_q   <= col_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
      end
   end

endmodule
